// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with pipeline stall, flush and divide-by-zero handling.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd;
    logic               sa, sb, dz_q;
    logic [2*WIDTH:0]   acc, acc_next;
    logic               is_div, is_mult_s, last, accept, div0;
    logic               sa_in, sb_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     upper, mext, sum, shifted, dvsr, rem_next;
    logic               ge;
    logic [WIDTH-1:0]   res_hi, res_lo, quo, rem;

    assign is_div    = op_q[1];
    assign is_mult_s = (op_q == 2'b00);
    assign last      = (cnt == CW'(WIDTH - 1));
    assign accept    = (state == IDLE) && start && !flush;
    assign div0      = accept && op[1] && (b == '0);

    // Only MULT (00) and DIV (10) treat operands as signed.
    assign sa_in = a[WIDTH-1] & ~op[0];
    assign sb_in = b[WIDTH-1] & ~op[0];
    assign mag_a = sa_in ? -a : a;
    assign mag_b = sb_in ? -b : b;

    always_comb begin
        upper    = acc[2*WIDTH:WIDTH];
        mext     = is_mult_s ? {opnd[WIDTH-1], opnd} : {1'b0, opnd};
        // The multiplier MSB carries negative weight in signed mode, so the last step subtracts.
        if (acc[0])
            sum = (is_mult_s && last) ? upper - mext : upper + mext;
        else
            sum = upper;
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        dvsr     = {1'b0, opnd};
        ge       = (shifted >= dvsr);
        rem_next = ge ? shifted - dvsr : shifted;
        if (is_div)
            acc_next = {1'b0, rem_next[WIDTH-1:0], acc[WIDTH-2:0], ge};
        else
            acc_next = {is_mult_s ? sum[WIDTH] : 1'b0, sum, acc[WIDTH-1:1]};

        quo = acc_next[WIDTH-1:0];
        rem = acc_next[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_lo = (sa ^ sb) ? -quo : quo;
            res_hi = sa ? -rem : rem;
        end else begin
            res_lo = acc_next[WIDTH-1:0];
            res_hi = acc_next[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = div0 ? DONE : CALC;
            CALC: begin
                if (flush)     state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall       = reset_n && (accept || (state == CALC && !flush));
    assign done        = reset_n && (state == DONE) && !flush;
    assign div_by_zero = done && dz_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            opnd  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz_q  <= 1'b0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= op;
                sa   <= sa_in;
                sb   <= sb_in;
                cnt  <= '0;
                dz_q <= div0;
                opnd <= op[1] ? mag_b : a;
                acc  <= {{(WIDTH+1){1'b0}}, op[1] ? mag_a : b};
                if (div0) begin
                    hi <= a;
                    lo <= '1;
                end
            end else if (state == CALC && !flush) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32): expected results are queued at issue
// and compared whenever done pulses; latency, stall, flush and reset behaviour checked inline.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n, start, flush;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          stall, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   failures = 0;
    int   done_cnt = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_by_zero", div_by_zero, e.dz);
            end
        end else if (div_by_zero) begin
            check("dz_outside_done", 1, 0);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                         input int exp_lat, input logic hold);
        int cyc, stalls;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        cyc = 0; stalls = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (done) break;
            if (stall) stalls++;
            @(posedge clk); #1;
            if (!hold) begin
                start = 1'b0;
                a = $urandom; b = $urandom; op = 2'($urandom);
            end
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("stall_cycles", stalls, exp_lat);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int dstart;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_by_zero, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        do_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33, 1'b0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 1'b0);
        do_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
        do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        do_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 1'b0);
        do_op(2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
        do_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1,  1'b0);

        // flush together with start in IDLE: nothing starts
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk);
        check("idle_flush_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_no_start", stall, 0);

        // flush mid-CALC retains the previous result
        do_op(2'b01, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0, 33, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        repeat (10) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_comb", stall, 0);
        check("flush_no_done", done, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_stall", stall, 0);
        check("post_flush_done", done, 0);
        check("flush_hi_kept", hi, 0);
        check("flush_lo_kept", lo, 35);
        do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 1'b0);

        // reset mid-CALC aborts and clears results
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        repeat (20) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_stall", stall, 0);
        check("reset_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_stall2", stall, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // start held high through DONE yields exactly one completion
        dstart = done_cnt;
        do_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 1'b1);
        repeat (40) @(negedge clk);
        check("single_done", done_cnt - dstart, 1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
